// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and types.
// Contents:
//   REG_W / DATA_W / ENTRY_W : register-number, data and queue-entry widths
//   ZERO_REG                 : hard-wired zero register; writes to it are dropped
//   wbEntry_t                : one queued writeback {register, data}
//   prioSel_e                : round-robin priority side
//   isWritable()             : true when an entry targets a real register
package regfile_wb_arbiter_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = REG_W + DATA_W;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prioSel_e;

  function automatic logic isWritable(input wbEntry_t e);
    return e.rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small circular queue of pending writebacks for one requester.
// Ports:
//   clock, resetL         : rising-edge clock, async active-low reset
//   pushValid/pushReady   : enqueue handshake; pushReady = not full
//   pushEntry             : entry to enqueue
//   popEn                 : dequeue the head this edge (ignored when empty)
//   headEntry, empty      : current head and empty flag
//   entryValid, entryRegs : per-slot occupancy and destination register,
//                           so the owner can run hazard lookups on every slot
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        resetL,
  input  logic                        pushValid,
  output logic                        pushReady,
  input  wbEntry_t                    pushEntry,
  input  logic                        popEn,
  output wbEntry_t                    headEntry,
  output logic                        empty,
  output logic [DEPTH-1:0]            entryValid,
  output logic [DEPTH-1:0][REG_W-1:0] entryRegs
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wbEntry_t         mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             doPush;
  logic             doPop;
  logic [PTR_W-1:0] offset;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign pushReady = !full;
  assign doPush    = pushValid && !full;
  assign doPop     = popEn && !empty;
  assign headEntry = mem[rdPtr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge resetL) begin
    if (!resetL) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  // A slot is live when its distance from the read pointer is below the
  // occupancy count.
  always_comb begin
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rdPtr;
      entryValid[i] = CNT_W'(offset) < count;
      entryRegs[i]  = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU (A) and load (B) writebacks into the single
// register-file write port.
// Ports:
//   Clock, Reset_L                   : rising-edge clock, async active-low reset
//   ReqX_Valid/Ready/Reg/Data (X=A,B): per-requester write offers
//   WriteReg, WriteData, RegWrite    : registered register-file write port
//   QueryReg, QueryPending           : hazard lookup against all pending writes
//   Busy                             : any write queued or in the output stage
// Handshake: a request is taken on a rising edge where Valid and Ready are
// both high. Ready depends only on queue fullness (never on Valid or on a
// same-edge pop) and is held low while Reset_L is low.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              ReqA_Valid,
  output logic              ReqA_Ready,
  input  logic [REG_W-1:0]  ReqA_Reg,
  input  logic [DATA_W-1:0] ReqA_Data,
  input  logic              ReqB_Valid,
  output logic              ReqB_Ready,
  input  logic [REG_W-1:0]  ReqB_Reg,
  input  logic [DATA_W-1:0] ReqB_Data,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [REG_W-1:0]  QueryReg,
  output logic              QueryPending,
  output logic              Busy
);

  logic                        fifoReadyA, fifoReadyB;
  logic                        emptyA, emptyB;
  wbEntry_t                    headA, headB;
  logic [DEPTH-1:0]            validA, validB;
  logic [DEPTH-1:0][REG_W-1:0] regsA, regsB;
  logic                        popA, popB;
  prioSel_e                    prio;
  wbEntry_t                    winner;
  logic                        doWrite;
  logic                        hit;

  wb_fifo #(.DEPTH(DEPTH)) fifoA (
    .clock      (Clock),
    .resetL     (Reset_L),
    .pushValid  (ReqA_Valid),
    .pushReady  (fifoReadyA),
    .pushEntry  ('{rd: ReqA_Reg, data: ReqA_Data}),
    .popEn      (popA),
    .headEntry  (headA),
    .empty      (emptyA),
    .entryValid (validA),
    .entryRegs  (regsA)
  );

  wb_fifo #(.DEPTH(DEPTH)) fifoB (
    .clock      (Clock),
    .resetL     (Reset_L),
    .pushValid  (ReqB_Valid),
    .pushReady  (fifoReadyB),
    .pushEntry  ('{rd: ReqB_Reg, data: ReqB_Data}),
    .popEn      (popB),
    .headEntry  (headB),
    .empty      (emptyB),
    .entryValid (validB),
    .entryRegs  (regsB)
  );

  assign ReqA_Ready = Reset_L && fifoReadyA;
  assign ReqB_Ready = Reset_L && fifoReadyB;

  // Round-robin grant: a lone non-empty queue always wins; on contention the
  // priority side wins.
  always_comb begin
    popA    = !emptyA && (emptyB || prio == PRIO_A);
    popB    = !emptyB && !popA;
    winner  = popA ? headA : headB;
    doWrite = (popA || popB) && isWritable(winner);
  end

  // Priority only rotates after a contended grant. Zero-register entries are
  // popped but leave WriteReg/WriteData untouched.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      prio      <= PRIO_A;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      if (!emptyA && !emptyB) prio <= popA ? PRIO_B : PRIO_A;
      RegWrite <= doWrite;
      if (doWrite) begin
        WriteReg  <= winner.rd;
        WriteData <= winner.data;
      end
    end
  end

  always_comb begin
    hit = RegWrite && (WriteReg == QueryReg);
    for (int i = 0; i < DEPTH; i++) begin
      if (validA[i] && regsA[i] == QueryReg) hit = 1'b1;
      if (validB[i] && regsB[i] == QueryReg) hit = 1'b1;
    end
    QueryPending = Reset_L && (QueryReg != ZERO_REG) && hit;
  end

  assign Busy = !emptyA || !emptyB || RegWrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic              Clock;
  logic              Reset_L;
  logic              ReqA_Valid, ReqA_Ready;
  logic [REG_W-1:0]  ReqA_Reg;
  logic [DATA_W-1:0] ReqA_Data;
  logic              ReqB_Valid, ReqB_Ready;
  logic [REG_W-1:0]  ReqB_Reg;
  logic [DATA_W-1:0] ReqB_Data;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [REG_W-1:0]  QueryReg;
  logic              QueryPending;
  logic              Busy;

  int checks   = 0;
  int failures = 0;
  logic [ENTRY_W-1:0] exp_q[$];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .Clock        (Clock),
    .Reset_L      (Reset_L),
    .ReqA_Valid   (ReqA_Valid),
    .ReqA_Ready   (ReqA_Ready),
    .ReqA_Reg     (ReqA_Reg),
    .ReqA_Data    (ReqA_Data),
    .ReqB_Valid   (ReqB_Valid),
    .ReqB_Ready   (ReqB_Ready),
    .ReqB_Reg     (ReqB_Reg),
    .ReqB_Data    (ReqB_Data),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .QueryReg     (QueryReg),
    .QueryPending (QueryPending),
    .Busy         (Busy)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] aData(input logic [4:0] r);
    return 32'hA000_0000 + 32'(r);
  endfunction

  function automatic logic [31:0] bData(input logic [4:0] r);
    return 32'hB000_0000 + 32'(r);
  endfunction

  function automatic void expectWrite(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic driveA(input logic [4:0] r, input logic [31:0] d);
    bit done = 0;
    ReqA_Valid = 1'b1;
    ReqA_Reg   = r;
    ReqA_Data  = d;
    for (int n = 0; n < 20 && !done; n++) begin
      done = ReqA_Ready;
      tick();
    end
    if (!done) checkEq("a_accept_timeout", 32'(done), 32'd1);
    ReqA_Valid = 1'b0;
  endtask

  task automatic driveB(input logic [4:0] r, input logic [31:0] d);
    bit done = 0;
    ReqB_Valid = 1'b1;
    ReqB_Reg   = r;
    ReqB_Data  = d;
    for (int n = 0; n < 20 && !done; n++) begin
      done = ReqB_Ready;
      tick();
    end
    if (!done) checkEq("b_accept_timeout", 32'(done), 32'd1);
    ReqB_Valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always begin
    logic [ENTRY_W-1:0] e;
    @(posedge Clock);
    #1;
    if (Reset_L === 1'b1 && RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkEq("spurious_write", 32'(RegWrite), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkEq("wb_reg", 32'(WriteReg), 32'(e[ENTRY_W-1:DATA_W]));
        checkEq("wb_data", WriteData, e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    Reset_L    = 1'b0;
    ReqA_Valid = 1'b1;
    ReqA_Reg   = 5'd9;
    ReqA_Data  = 32'h9;
    ReqB_Valid = 1'b0;
    ReqB_Reg   = '0;
    ReqB_Data  = '0;
    QueryReg   = 5'd9;

    // reset state, with A offering a write that must not be taken
    #12;
    checkEq("rst_a_ready", 32'(ReqA_Ready), 32'd0);
    checkEq("rst_b_ready", 32'(ReqB_Ready), 32'd0);
    checkEq("rst_regwrite", 32'(RegWrite), 32'd0);
    checkEq("rst_writereg", 32'(WriteReg), 32'd0);
    checkEq("rst_writedata", WriteData, 32'd0);
    checkEq("rst_busy", 32'(Busy), 32'd0);
    checkEq("rst_qp", 32'(QueryPending), 32'd0);
    #8;
    ReqA_Valid = 1'b0;
    #3;
    Reset_L = 1'b1;
    tick();

    // single write: accepted at edge N, RegWrite during N+1..N+2
    QueryReg   = 5'd3;
    ReqA_Valid = 1'b1;
    ReqA_Reg   = 5'd3;
    ReqA_Data  = 32'h1234;
    checkEq("t1_ready", 32'(ReqA_Ready), 32'd1);
    expectWrite(5'd3, 32'h1234);
    tick();
    ReqA_Valid = 1'b0;
    checkEq("t1_no_bypass", 32'(RegWrite), 32'd0);
    checkEq("t1_busy_queued", 32'(Busy), 32'd1);
    checkEq("t1_qp_queued", 32'(QueryPending), 32'd1);
    tick();
    checkEq("t1_regwrite", 32'(RegWrite), 32'd1);
    checkEq("t1_writereg", 32'(WriteReg), 32'd3);
    checkEq("t1_writedata", WriteData, 32'h1234);
    tick();
    checkEq("t1_one_cycle", 32'(RegWrite), 32'd0);
    checkEq("t1_busy_falls", 32'(Busy), 32'd0);
    checkEq("t1_qp_clear", 32'(QueryPending), 32'd0);

    // both requesters streaming: strict alternation starting with A
    QueryReg = 5'd0;
    expectWrite(5'd1, aData(5'd1));
    expectWrite(5'd4, bData(5'd4));
    expectWrite(5'd2, aData(5'd2));
    expectWrite(5'd5, bData(5'd5));
    expectWrite(5'd3, aData(5'd3));
    expectWrite(5'd6, bData(5'd6));
    fork
      begin
        driveA(5'd1, aData(5'd1));
        driveA(5'd2, aData(5'd2));
        driveA(5'd3, aData(5'd3));
      end
      begin
        driveB(5'd4, bData(5'd4));
        driveB(5'd5, bData(5'd5));
        driveB(5'd6, bData(5'd6));
      end
      begin
        int n = 0;
        while (RegWrite !== 1'b1 && n < 10) begin
          tick();
          n++;
        end
        if (n == 10) checkEq("t2_first_write_timeout", 32'(RegWrite), 32'd1);
        for (int k = 0; k < 6; k++) begin
          checkEq("t2_back_to_back", 32'(RegWrite), 32'd1);
          tick();
        end
        checkEq("t2_idle_after", 32'(RegWrite), 32'd0);
      end
    join

    // A backs up behind its full queue while B keeps the write port busy;
    // priority is on B after the previous stream
    expectWrite(5'd12, bData(5'd12));
    expectWrite(5'd8,  aData(5'd8));
    expectWrite(5'd13, bData(5'd13));
    expectWrite(5'd9,  aData(5'd9));
    expectWrite(5'd14, bData(5'd14));
    expectWrite(5'd10, aData(5'd10));
    expectWrite(5'd15, bData(5'd15));
    fork
      begin
        driveA(5'd8,  aData(5'd8));
        driveA(5'd9,  aData(5'd9));
        driveA(5'd10, aData(5'd10));
      end
      begin
        driveB(5'd12, bData(5'd12));
        driveB(5'd13, bData(5'd13));
        driveB(5'd14, bData(5'd14));
        driveB(5'd15, bData(5'd15));
      end
      begin
        tick();
        checkEq("t3_a_ready_one", 32'(ReqA_Ready), 32'd1);
        tick();
        checkEq("t3_a_ready_full", 32'(ReqA_Ready), 32'd0);
        tick();
        checkEq("t3_a_ready_after_pop", 32'(ReqA_Ready), 32'd1);
      end
    join
    begin
      int n = 0;
      while (Busy !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      checkEq("t3_drained", 32'(Busy), 32'd0);
    end

    // zero-register write is popped silently
    QueryReg   = 5'd0;
    ReqA_Valid = 1'b1;
    ReqA_Reg   = 5'd0;
    ReqA_Data  = 32'hFFFF_FFFF;
    checkEq("t4_qp_before", 32'(QueryPending), 32'd0);
    tick();
    ReqA_Valid = 1'b0;
    checkEq("t4_qp_queued", 32'(QueryPending), 32'd0);
    checkEq("t4_no_write_q", 32'(RegWrite), 32'd0);
    checkEq("t4_busy_queued", 32'(Busy), 32'd1);
    tick();
    checkEq("t4_no_write_pop", 32'(RegWrite), 32'd0);
    checkEq("t4_qp_pop", 32'(QueryPending), 32'd0);
    checkEq("t4_hold_reg", 32'(WriteReg), 32'd15);
    checkEq("t4_hold_data", WriteData, 32'hB000_000F);
    checkEq("t4_busy_after", 32'(Busy), 32'd0);

    // hazard lookup follows a B entry from queue to output stage
    QueryReg   = 5'd7;
    checkEq("t5_qp_idle", 32'(QueryPending), 32'd0);
    ReqB_Valid = 1'b1;
    ReqB_Reg   = 5'd7;
    ReqB_Data  = 32'h77;
    expectWrite(5'd7, 32'h77);
    tick();
    ReqB_Valid = 1'b0;
    checkEq("t5_qp_queued", 32'(QueryPending), 32'd1);
    QueryReg = 5'd8;
    #1;
    checkEq("t5_qp_other_reg", 32'(QueryPending), 32'd0);
    QueryReg = 5'd7;
    tick();
    checkEq("t5_regwrite", 32'(RegWrite), 32'd1);
    checkEq("t5_qp_output", 32'(QueryPending), 32'd1);
    tick();
    checkEq("t5_qp_cleared", 32'(QueryPending), 32'd0);

    // fill queues, then reset mid-cycle; priority is on B going in
    QueryReg = 5'd21;
    expectWrite(5'd24, bData(5'd24));
    fork
      begin
        driveA(5'd20, aData(5'd20));
        driveA(5'd21, aData(5'd21));
      end
      begin
        driveB(5'd24, bData(5'd24));
        driveB(5'd25, bData(5'd25));
      end
    join
    checkEq("t6_regwrite_before", 32'(RegWrite), 32'd1);
    checkEq("t6_qp_before", 32'(QueryPending), 32'd1);
    checkEq("t6_a_full_before", 32'(ReqA_Ready), 32'd0);
    checkEq("t6_b_ready_before", 32'(ReqB_Ready), 32'd1);
    #3;
    Reset_L = 1'b0;
    #1;
    checkEq("t6_rst_regwrite", 32'(RegWrite), 32'd0);
    checkEq("t6_rst_a_ready", 32'(ReqA_Ready), 32'd0);
    checkEq("t6_rst_b_ready", 32'(ReqB_Ready), 32'd0);
    checkEq("t6_rst_busy", 32'(Busy), 32'd0);
    checkEq("t6_rst_qp", 32'(QueryPending), 32'd0);
    checkEq("t6_rst_writereg", 32'(WriteReg), 32'd0);
    checkEq("t6_rst_writedata", WriteData, 32'd0);
    tick();
    tick();
    #3;
    Reset_L = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkEq("t6_no_stale_write", 32'(RegWrite), 32'd0);
      checkEq("t6_no_stale_busy", 32'(Busy), 32'd0);
    end
    checkEq("t6_qp_after", 32'(QueryPending), 32'd0);

    // first contended grant after reset goes to A
    ReqA_Valid = 1'b1;
    ReqA_Reg   = 5'd30;
    ReqA_Data  = aData(5'd30);
    ReqB_Valid = 1'b1;
    ReqB_Reg   = 5'd31;
    ReqB_Data  = bData(5'd31);
    expectWrite(5'd30, aData(5'd30));
    expectWrite(5'd31, bData(5'd31));
    checkEq("t6_a_ready_after", 32'(ReqA_Ready), 32'd1);
    checkEq("t6_b_ready_after", 32'(ReqB_Ready), 32'd1);
    tick();
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b0;
    tick();
    checkEq("t6_first_grant_a", 32'(WriteReg), 32'd30);
    tick();
    checkEq("t6_second_grant_b", 32'(WriteReg), 32'd31);
    tick();
    checkEq("t6_final_idle", 32'(Busy), 32'd0);

    // ---------------- report ----------------
    checkEq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
